// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle core: opcodes, FSM states, ALU ops
// and small opcode-classification helpers.
package mc_pkg;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_SLT  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h10;
  localparam logic [5:0] OP_ORI  = 6'h11;
  localparam logic [5:0] OP_LUI  = 6'h13;
  localparam logic [5:0] OP_LW   = 6'h20;
  localparam logic [5:0] OP_SW   = 6'h21;
  localparam logic [5:0] OP_BEQ  = 6'h30;
  localparam logic [5:0] OP_J    = 6'h31;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_LUI
  } alu_op_t;

  // R-form opcodes occupy 00..05 and write rd instead of rt.
  function automatic logic is_rform(input logic [5:0] op);
    return (op <= OP_SLT);
  endfunction

  // Opcodes that execute normally (HALT is legal but handled separately).
  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
      OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  function automatic alu_op_t alu_sel(input logic [5:0] op);
    case (op)
      OP_SUB, OP_BEQ: return ALU_SUB;
      OP_AND:         return ALU_AND;
      OP_OR, OP_ORI:  return ALU_OR;
      OP_XOR:         return ALU_XOR;
      OP_SLT:         return ALU_SLT;
      OP_LUI:         return ALU_LUI;
      default:        return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// r0 always reads zero and ignores writes.
module mc_regfile #(
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_REGS   = 32,
  localparam int REG_AW     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_AW-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [REG_AW-1:0]     raddr_a,
  input  logic [REG_AW-1:0]     raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Write port; register clear on reset, r0 writes discarded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mc_datapath_hs.sv
// Multicycle CPU core with IR/A/B/ALUOut/MDR registers, handshaked
// instruction/data memories, HALT and sticky illegal-opcode trap.
module mc_datapath_hs
  import mc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 16,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [PC_WIDTH-1:0]   dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [31:0]           instr,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic [2:0]            state,
  output logic                  retire,
  output logic                  halted,
  output logic                  illegal
);

  localparam int REG_AW = $clog2(NUM_REGS);

  state_t                cur, nxt;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [31:0]           ir;
  logic [DATA_WIDTH-1:0] a_q, b_q, alu_q, mdr_q;
  logic                  illegal_q;

  logic [5:0]            op;
  logic [REG_AW-1:0]     rs_idx, rt_idx, rd_idx;
  logic [15:0]           imm;
  logic [DATA_WIDTH-1:0] imm_se, imm_ze, opb, alu_res;
  logic [PC_WIDTH-1:0]   pc_off, j_target;
  logic [DATA_WIDTH-1:0] rf_a, rf_b, rf_wdata;
  logic [REG_AW-1:0]     rf_waddr;
  logic                  rf_we;

  assign op       = ir[31:26];
  assign rs_idx   = ir[21 +: REG_AW];
  assign rt_idx   = ir[16 +: REG_AW];
  assign rd_idx   = ir[11 +: REG_AW];
  assign imm      = ir[15:0];
  assign imm_se   = DATA_WIDTH'($signed(imm));
  assign imm_ze   = DATA_WIDTH'(imm);
  assign pc_off   = PC_WIDTH'($signed(imm));
  assign j_target = PC_WIDTH'(ir[25:0]);

  mc_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rs_idx),
    .raddr_b (rt_idx),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  // ALU: second operand is B for R-form, zero-extended imm for ORI, else sign-extended imm
  always_comb begin
    opb     = is_rform(op) ? b_q : ((op == OP_ORI) ? imm_ze : imm_se);
    alu_res = '0;
    case (alu_sel(op))
      ALU_SUB: alu_res = a_q - opb;
      ALU_AND: alu_res = a_q & opb;
      ALU_OR:  alu_res = a_q | opb;
      ALU_XOR: alu_res = a_q ^ opb;
      ALU_SLT: alu_res[0] = ($signed(a_q) < $signed(opb));
      ALU_LUI: alu_res = imm_ze << (DATA_WIDTH - 16);
      default: alu_res = a_q + opb;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  // FSM next-state logic; FETCH and MEM stall until their memory is ready
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  if (imem_ready) nxt = S_DECODE;
      S_DECODE: nxt = ((op == OP_HALT) || !op_legal(op)) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if ((op == OP_BEQ) || (op == OP_J))     nxt = S_FETCH;
        else if ((op == OP_LW) || (op == OP_SW)) nxt = S_MEM;
        else                                     nxt = S_WB;
      end
      S_MEM:    if (dmem_ready) nxt = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:     nxt = S_FETCH;
      default:  nxt = S_HALT;
    endcase
  end

  // FSM outputs; requests are gated by reset so they drop without waiting for a clock
  always_comb begin
    imem_req = (cur == S_FETCH) && !reset;
    dmem_req = (cur == S_MEM) && !reset;
    dmem_we  = (cur == S_MEM) && (op == OP_SW) && !reset;
    rf_we    = (cur == S_WB);
    retire   = 1'b0;
    if (!reset) begin
      case (cur)
        S_EXEC:  retire = (op == OP_BEQ) || (op == OP_J);
        S_MEM:   retire = dmem_ready && (op == OP_SW);
        S_WB:    retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  // Datapath registers: IR/PC on fetch, A/B on decode, ALUOut and branch on exec, MDR on load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (cur)
        S_FETCH: begin
          if (imem_ready) begin
            ir   <= imem_rdata;
            pc_q <= pc_q + PC_WIDTH'(1);
          end
        end
        S_DECODE: begin
          a_q <= rf_a;
          b_q <= rf_b;
          if (!op_legal(op)) illegal_q <= 1'b1;
        end
        S_EXEC: begin
          alu_q <= alu_res;
          // pc already points past the branch, so the offset is added directly
          if (op == OP_J)                        pc_q <= j_target;
          else if ((op == OP_BEQ) && (a_q == b_q)) pc_q <= pc_q + pc_off;
        end
        S_MEM: begin
          if (dmem_ready && (op == OP_LW)) mdr_q <= dmem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign rf_waddr   = is_rform(op) ? rd_idx : rt_idx;
  assign rf_wdata   = (op == OP_LW) ? mdr_q : alu_q;

  assign imem_addr  = pc_q;
  assign dmem_addr  = alu_q[PC_WIDTH-1:0];
  assign dmem_wdata = b_q;
  assign pc         = pc_q;
  assign instr      = ir;
  assign alu_out    = alu_q;
  assign state      = cur;
  assign halted     = (cur == S_HALT);
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_mc_datapath_hs.sv
// Directed self-checking bench for mc_datapath_hs with simple
// instruction/data memory models and a configurable data-memory wait.
module tb_mc_datapath_hs;

  localparam int DW = 32;
  localparam int PW = 16;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req, imem_ready;
  logic [PW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          dmem_req, dmem_we, dmem_ready;
  logic [PW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic [PW-1:0] pc;
  logic [31:0]   instr;
  logic [DW-1:0] alu_out;
  logic [2:0]    state;
  logic          retire, halted, illegal;

  mc_datapath_hs #(
    .DATA_WIDTH (DW),
    .PC_WIDTH   (PW),
    .NUM_REGS   (NR)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .instr      (instr),
    .alu_out    (alu_out),
    .state      (state),
    .retire     (retire),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Memory models: zero-wait instruction memory, data memory with dmem_lat wait cycles
  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int          dmem_lat = 0;
  int          dm_cnt = 0;

  assign imem_ready = imem_req;
  assign imem_rdata = imem[imem_addr[5:0]];
  assign dmem_ready = dmem_req && (dm_cnt >= dmem_lat);
  assign dmem_rdata = dmem[dmem_addr[5:0]];

  always @(posedge clk) begin
    if (dmem_req && !dmem_ready) dm_cnt <= dm_cnt + 1;
    else                         dm_cnt <= 0;
    if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[5:0]] <= dmem_wdata;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Per-run observations
  int            ret_n, f_n, cyc;
  int            ret_cyc [16];
  logic [31:0]   ret_alu [16];
  logic [PW-1:0] ret_pc  [16];
  logic [PW-1:0] fetch_pc[16];
  int            dreq_cycles, dwe_cycles, unstable;
  logic [PW-1:0] first_daddr;
  logic          seen_dreq;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      imem[i] = {6'h3F, 26'h0};
      dmem[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Runs from reset release, sampling each negedge; cycle 1 is the first cycle after release
  task automatic run(input int max_cyc, input int n_ret);
    logic          prev_req;
    logic [PW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    logic          prev_we;
    ret_n = 0; f_n = 0; cyc = 0;
    dreq_cycles = 0; dwe_cycles = 0; unstable = 0; seen_dreq = 1'b0; first_daddr = '0;
    prev_req = 1'b0; prev_addr = '0; prev_wdata = '0; prev_we = 1'b0;
    while ((cyc < max_cyc) && (ret_n < n_ret) && !halted) begin
      @(negedge clk);
      cyc++;
      if (imem_req && imem_ready && f_n < 16) begin
        fetch_pc[f_n] = pc;
        f_n++;
      end
      if (dmem_req) begin
        dreq_cycles++;
        if (dmem_we) dwe_cycles++;
        if (!seen_dreq) first_daddr = dmem_addr;
        seen_dreq = 1'b1;
        if (prev_req && ((dmem_addr !== prev_addr) || (dmem_we !== prev_we) ||
                         (dmem_wdata !== prev_wdata)))
          unstable++;
      end
      prev_req = dmem_req && !dmem_ready;
      prev_addr = dmem_addr; prev_we = dmem_we; prev_wdata = dmem_wdata;
      if (retire && ret_n < 16) begin
        ret_cyc[ret_n] = cyc;
        ret_alu[ret_n] = alu_out;
        ret_pc[ret_n]  = pc;
        ret_n++;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if ({pc, instr, alu_out, state} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs pc=%h instr=%h alu=%h state=%0d exp all 0", pc, instr, alu_out, state);
    end
    n_tests++;
    if ({imem_req, dmem_req, dmem_we, retire, halted, illegal} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 000000",
               {imem_req, dmem_req, dmem_we, retire, halted, illegal});
    end
    do_reset();
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_release imem_req=%b addr=%h exp 1/0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_arith();
    clear_mem();
    dmem_lat = 0;
    imem[0] = enc_i(6'h10, 0, 1, 16'd5);
    imem[1] = enc_i(6'h10, 0, 2, 16'hFFFD);
    imem[2] = enc_r(6'h00, 1, 2, 3);
    do_reset();
    run(40, 3);
    n_tests++;
    if (ret_n !== 3) begin
      n_fail++;
      $display("FAIL arith_retires got %0d exp 3", ret_n);
    end else begin
      n_tests++;
      if (ret_cyc[0] !== 4 || ret_cyc[1] !== 8 || ret_cyc[2] !== 12) begin
        n_fail++;
        $display("FAIL arith_cycles got %0d,%0d,%0d exp 4,8,12", ret_cyc[0], ret_cyc[1], ret_cyc[2]);
      end
      n_tests++;
      if (ret_alu[0] !== 32'd5 || ret_alu[1] !== 32'hFFFFFFFD) begin
        n_fail++;
        $display("FAIL arith_addi got %h,%h exp 00000005,fffffffd", ret_alu[0], ret_alu[1]);
      end
      n_tests++;
      if (ret_alu[2] !== 32'd2) begin
        n_fail++;
        $display("FAIL arith_add got %h exp 00000002", ret_alu[2]);
      end
    end
  endtask

  task automatic test_mem_wait();
    clear_mem();
    dmem_lat = 3;
    imem[0] = enc_i(6'h10, 0, 1, 16'd5);
    imem[1] = enc_i(6'h21, 0, 1, 16'd4);
    imem[2] = enc_i(6'h20, 0, 4, 16'd4);
    imem[3] = enc_r(6'h00, 4, 0, 7);
    do_reset();
    run(80, 4);
    n_tests++;
    if (ret_n !== 4) begin
      n_fail++;
      $display("FAIL mem_retires got %0d exp 4", ret_n);
    end else begin
      n_tests++;
      if (ret_cyc[1] !== 11 || ret_cyc[2] !== 19 || ret_cyc[3] !== 23) begin
        n_fail++;
        $display("FAIL mem_cycles got %0d,%0d,%0d exp 11,19,23", ret_cyc[1], ret_cyc[2], ret_cyc[3]);
      end
      n_tests++;
      if (ret_cyc[2] - ret_cyc[1] !== 8) begin
        n_fail++;
        $display("FAIL lw_latency got %0d exp 8", ret_cyc[2] - ret_cyc[1]);
      end
      n_tests++;
      if (ret_alu[3] !== 32'd5) begin
        n_fail++;
        $display("FAIL lw_value r4 got %h exp 00000005", ret_alu[3]);
      end
    end
    n_tests++;
    if (dreq_cycles !== 8 || dwe_cycles !== 4) begin
      n_fail++;
      $display("FAIL dmem_req_len got req=%0d we=%0d exp 8/4", dreq_cycles, dwe_cycles);
    end
    n_tests++;
    if (unstable !== 0 || first_daddr !== 16'd4) begin
      n_fail++;
      $display("FAIL dmem_stable got changes=%0d addr=%h exp 0/0004", unstable, first_daddr);
    end
    n_tests++;
    if (dmem[4] !== 32'd5) begin
      n_fail++;
      $display("FAIL sw_store got %h exp 00000005", dmem[4]);
    end
    dmem_lat = 0;
  endtask

  task automatic test_branch();
    // Taken BEQ back onto itself
    clear_mem();
    dmem_lat = 0;
    imem[0] = enc_i(6'h10, 0, 1, 16'd5);
    imem[1] = enc_i(6'h10, 0, 2, 16'hFFFD);
    imem[2] = {6'h31, 26'd7};
    imem[7] = enc_i(6'h30, 1, 1, 16'hFFFF);
    do_reset();
    run(40, 4);
    n_tests++;
    if (ret_n !== 4 || ret_cyc[2] !== 11 || ret_cyc[3] !== 14) begin
      n_fail++;
      $display("FAIL beq_taken_cycles got n=%0d j=%0d beq=%0d exp 4/11/14", ret_n, ret_cyc[2], ret_cyc[3]);
    end
    @(negedge clk);
    n_tests++;
    if (pc !== 16'd7 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL beq_taken_pc got pc=%h state=%0d exp 0007/0", pc, state);
    end
    // Not-taken BEQ, then J with a target wider than the pc, then pc wrap
    clear_mem();
    imem[0]  = enc_i(6'h10, 0, 1, 16'd5);
    imem[1]  = enc_i(6'h10, 0, 2, 16'hFFFD);
    imem[2]  = {6'h31, 26'd7};
    imem[7]  = enc_i(6'h30, 1, 2, 16'hFFFF);
    imem[8]  = {6'h31, 26'h3FFFF};
    imem[63] = enc_i(6'h10, 0, 3, 16'd9);
    do_reset();
    run(60, 6);
    n_tests++;
    if (f_n < 6 || fetch_pc[4] !== 16'd8 || fetch_pc[5] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL beq_nt_jtrunc got n=%0d f4=%h f5=%h exp 8/0008/ffff", f_n, fetch_pc[4], fetch_pc[5]);
    end
    n_tests++;
    if (ret_n !== 6 || ret_pc[5] !== 16'h0 || ret_alu[5] !== 32'd9) begin
      n_fail++;
      $display("FAIL pc_wrap got n=%0d pc=%h alu=%h exp 6/0000/00000009", ret_n, ret_pc[5], ret_alu[5]);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] exp_alu [13];
    clear_mem();
    dmem_lat = 0;
    imem[0]  = enc_i(6'h10, 0, 1, 16'd5);       exp_alu[0]  = 32'h00000005;
    imem[1]  = enc_i(6'h10, 0, 2, 16'hFFFD);    exp_alu[1]  = 32'hFFFFFFFD;
    imem[2]  = enc_r(6'h05, 2, 1, 5);           exp_alu[2]  = 32'h00000001;
    imem[3]  = enc_r(6'h05, 1, 2, 8);           exp_alu[3]  = 32'h00000000;
    imem[4]  = enc_i(6'h13, 0, 6, 16'hABCD);    exp_alu[4]  = 32'hABCD0000;
    imem[5]  = enc_r(6'h00, 1, 1, 0);           exp_alu[5]  = 32'h0000000A;
    imem[6]  = enc_r(6'h00, 0, 0, 7);           exp_alu[6]  = 32'h00000000;
    imem[7]  = enc_r(6'h01, 1, 2, 10);          exp_alu[7]  = 32'h00000008;
    imem[8]  = enc_r(6'h04, 1, 2, 11);          exp_alu[8]  = 32'hFFFFFFF8;
    imem[9]  = enc_r(6'h02, 1, 2, 12);          exp_alu[9]  = 32'h00000005;
    imem[10] = enc_r(6'h03, 1, 2, 13);          exp_alu[10] = 32'hFFFFFFFD;
    imem[11] = enc_i(6'h11, 0, 9, 16'h8000);    exp_alu[11] = 32'h00008000;
    imem[12] = enc_i(6'h10, 6, 14, 16'hFFFF);   exp_alu[12] = 32'hABCCFFFF;
    do_reset();
    run(80, 13);
    n_tests++;
    if (ret_n !== 13) begin
      n_fail++;
      $display("FAIL alu_retires got %0d exp 13", ret_n);
    end
    for (int i = 0; i < 13; i++) begin
      if (i < ret_n) begin
        n_tests++;
        if (ret_alu[i] !== exp_alu[i] || ret_cyc[i] !== 4 * (i + 1)) begin
          n_fail++;
          $display("FAIL alu_op%0d got %h @%0d exp %h @%0d", i, ret_alu[i], ret_cyc[i],
                   exp_alu[i], 4 * (i + 1));
        end
      end
    end
  endtask

  task automatic test_halt_illegal();
    clear_mem();
    dmem_lat = 0;
    imem[0] = {6'h2A, 26'h0};
    do_reset();
    run(20, 1);
    repeat (3) @(negedge clk);
    n_tests++;
    if (illegal !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || state !== 3'd5 || ret_n !== 0) begin
      n_fail++;
      $display("FAIL illegal_trap got ill=%b halt=%b req=%b state=%0d ret=%0d exp 1/1/0/5/0",
               illegal, halted, imem_req, state, ret_n);
    end
    clear_mem();
    do_reset();
    run(20, 1);
    @(negedge clk);
    n_tests++;
    if (illegal !== 1'b0 || halted !== 1'b1 || imem_req !== 1'b0 || cyc !== 3) begin
      n_fail++;
      $display("FAIL halt_op got ill=%b halt=%b req=%b cyc=%0d exp 0/1/0/3", illegal, halted, imem_req, cyc);
    end
  endtask

  task automatic test_reset_midmem();
    int waited;
    clear_mem();
    dmem_lat = 10;
    imem[0] = enc_i(6'h10, 0, 1, 16'd5);
    imem[1] = enc_i(6'h21, 0, 1, 16'd4);
    do_reset();
    run(20, 1);
    waited = 0;
    while (!dmem_req && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (dmem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL midmem_reach got dmem_req=%b exp 1", dmem_req);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_req !== 1'b0 || pc !== 16'h0 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset got dreq=%b we=%b ireq=%b pc=%h state=%0d exp 0/0/0/0000/0",
               dmem_req, dmem_we, imem_req, pc, state);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b1 || pc !== 16'h0 || state !== 3'd0 || dmem[4] !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset got ireq=%b pc=%h state=%0d m4=%h exp 1/0000/0/00000000",
               imem_req, pc, state, dmem[4]);
    end
    dmem_lat = 0;
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_arith();
    test_mem_wait();
    test_branch();
    test_alu_ops();
    test_halt_illegal();
    test_reset_midmem();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
